// File: rtl/byte_arb_pkg.sv
// Shared state encoding and default sizing for the byte-path arbiter slice.
package byte_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/byte_path_arbiter_if.sv
// Requester/downstream handshake bundle for the byte-path arbiter.
// slave is the arbiter view; master is the requesters plus downstream sink.
interface byte_path_arbiter_if
  import byte_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic [SRC_W-1:0]         out_src;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, grant, out_data, out_valid, out_src, busy
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, grant, out_data, out_valid, out_src, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
// Zero latency; i_last itself has the lowest priority.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  logic [IDX_W-1:0] w_idx;

  // Walk from farthest to nearest so the nearest hit overwrites earlier ones.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last) + k) % N);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_path_arbiter.sv
// Round-robin burst arbiter feeding a one-deep registered byte output stage.
// One IDLE cycle of arbitration per burst, then 1 beat/cycle; stalls hold the owner and its beat count.
module byte_path_arbiter
  import byte_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  byte_path_arbiter_if.slave bus
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(NUM_REQ - 1);

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [SRC_W-1:0]   r_owner, w_owner_nxt;
  logic [SRC_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic [SRC_W-1:0]   r_out_src;

  logic [SRC_W-1:0]   w_winner;
  logic               w_any;
  logic               w_space;
  logic               w_owner_vld;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [WIDTH-1:0]   w_owner_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req    (bus.req_valid),
    .i_last   (r_last_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_space      = !r_out_valid || bus.out_ready;
  assign w_owner_vld  = bus.req_valid[r_owner];
  assign w_accept     = (r_state == ST_BURST) && w_owner_vld && w_space;
  assign w_owner_data = bus.req_data[int'(r_owner)*WIDTH +: WIDTH];

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_grant <= LAST_REQ;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt           = ST_BURST;
          w_grant_nxt           = '0;
          w_grant_nxt[w_winner] = 1'b1;
          w_owner_nxt           = w_winner;
          w_beat_cnt_nxt        = '0;
        end
      end
      ST_BURST: begin
        // Release on the first idle cycle of the owner, even while stalled downstream.
        if (!w_owner_vld || (w_accept && r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt      = ST_IDLE;
          w_grant_nxt      = '0;
          w_last_grant_nxt = r_owner;
        end
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_owner_data;
      r_out_src   <= r_owner;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.grant     = r_grant;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_src   = r_out_src;
  assign bus.busy      = (r_state == ST_BURST);

endmodule

// File: doc/byte_path_arbiter.md
Name: byte_path_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single registered byte datapath (data_in -> data_out register stage) between NUM_REQ requesters. It grants one requester at a time for a bounded burst of beats and forwards accepted bytes through a one-deep output register with valid/ready handshake. It sits in front of the byte register stage and is the only writer of that stage.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width per beat
MAX_BURST, 4, max beats accepted per grant (>=1)
SRC_W, $clog2(NUM_REQ), width of source index (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*WIDTH  flattened beat data; requester i at [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  per-requester accept strobe (combinational)
grant  output  NUM_REQ  one-hot current owner, 0 in IDLE (registered)
out_data  output  WIDTH  registered data to byte datapath
out_valid  output  1  out_data valid
out_src  output  SRC_W  index of requester that produced out_data
out_ready  input  1  downstream accept
busy  output  1  high in BURST

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst). Assertion clears immediately, regardless of clk.
- Reset values: state=IDLE, grant=0, out_valid=0, out_data=0, out_src=0, beat_cnt=0, last_grant=NUM_REQ-1 (requester 0 wins first), busy=0. req_ready=0 follows combinationally.
- States: IDLE, BURST.
- IDLE: if any req_valid, pick the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap. Register grant=onehot(winner), state=BURST, beat_cnt=0. No beat is accepted in IDLE, so there is 1 cycle arbitration latency. If no request, stay IDLE.
- BURST, owner g:
  - Space condition: space = !out_valid || out_ready.
  - Ready: req_ready[g] = req_valid[g] && space; all other req_ready bits are 0.
  - Accept (req_valid[g] && space): out_data<=req_data[g], out_src<=g, out_valid<=1, beat_cnt++.
  - If the accept has beat_cnt==MAX_BURST-1: go IDLE, grant<=0, last_grant<=g.
  - If req_valid[g]==0: go IDLE, grant<=0, last_grant<=g. Release is on the first non-valid cycle, including while stalled.
  - If req_valid[g]==1 and there is no space: hold state and beat_cnt.
- Output register:
  - If a beat is accepted, the register loads.
  - Else if out_ready, out_valid<=0.
  - Else it holds; out_data and out_src stay stable while out_valid && !out_ready.
  - Full throughput is 1 beat/cycle inside a burst, with a 1-cycle IDLE bubble between bursts.
- Fairness: a requester that just released has lowest priority next arbitration. Each continuously requesting requester is served within NUM_REQ-1 other bursts.
- Requests from non-owners during BURST are ignored; they are not latched.
- beat_cnt width is $clog2(MAX_BURST+1) and never wraps. For MAX_BURST=1, every accept returns to IDLE.
- Reset mid-burst: out_valid drops asynchronously, the in-flight beat is lost, and arbitration restarts at requester 0.

Decomposition:
- Package byte_arb_pkg: state encoding (ST_IDLE=1'b0, ST_BURST=1'b1) and default constants for NUM_REQ, WIDTH, MAX_BURST.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and last_grant index; outputs are winner index and any_req. It is instantiated once, and is reusable by other arbiters.

Test Plan:
- Reset then req_valid=4'b0001, data 0xA0..0xA5, out_ready=1 -> grant=0001 cycle after request; out_data A0,A1,A2,A3 on consecutive cycles, out_src=0. Then one IDLE cycle, regrant 0, and A4,A5 follow.
- req_valid=4'b1111 steady, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001. Each burst is exactly 4 beats with correct out_src.
- Owner 2, out_ready=0 after first beat 0x5C -> out_valid=1, out_data=0x5C held stable and req_ready[2]=0. On out_ready=1, the next beat is accepted the same cycle.
- Owner 1 drops req_valid after 2 beats -> busy=0 next cycle, and requester 2 (valid) wins next even though requester 0 is also valid.
- MAX_BURST=1 build, req_valid=4'b0101 -> beats alternate src 0,2,0,2 with IDLE bubbles between.
- rst asserted mid-burst with out_valid=1 -> out_valid, grant, busy go 0 without a clk edge. After release, with req_valid=4'b1000|4'b0001, requester 0 wins first.
